accessor: RTL and testbench

- Memory-access stage of the pipeline, downstream of the executor.
- Accepts one executor_output per handshake and passes ALU results through.
- For load/store ops, performs one aligned 32-bit data-bus transaction: byte/half lane steering, sign/zero extension, misalignment and bus-timeout detection.
- Presents an accessor_output to the writeback stage under a valid/ready handshake.

---
 rtl/accessor_pkg.sv | 47 ++++
 rtl/accessor_load_aligner.sv | 35 +++
 rtl/accessor.sv | 157 +++++++++++++++
 tb/tb_accessor.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/accessor_pkg.sv
// Shared types for the memory-access stage: pipeline payloads, stage state,
// store byte-enable patterns and small decode helpers.
package accessor_pkg;

    typedef struct packed {
        logic [4:0]  rd;
        logic [31:0] rd_data;
        logic [31:0] mem_addr;
        logic [31:0] mem_data;
        logic        is_lb;
        logic        is_lbu;
        logic        is_lh;
        logic        is_lhu;
        logic        is_lw;
        logic        is_sb;
        logic        is_sh;
        logic        is_sw;
    } executor_output;

    typedef struct packed {
        logic [4:0]  rd;
        logic [31:0] rd_data;
        logic        misaligned;
        logic        bus_error;
    } accessor_output;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUS  = 2'd1,
        ST_HOLD = 2'd2
    } accessor_state_e;

    localparam logic [3:0] WSTRB_BYTE = 4'b0001;
    localparam logic [3:0] WSTRB_HALF = 4'b0011;
    localparam logic [3:0] WSTRB_WORD = 4'b1111;

    function automatic logic is_mem_op(input executor_output op);
        return op.is_lb | op.is_lbu | op.is_lh | op.is_lhu |
               op.is_lw | op.is_sb | op.is_sh | op.is_sw;
    endfunction

    function automatic logic is_misaligned(input executor_output op);
        return ((op.is_lh | op.is_lhu | op.is_sh) & op.mem_addr[0]) |
               ((op.is_lw | op.is_sw) & (op.mem_addr[1:0] != 2'b00));
    endfunction

endpackage

// File: rtl/accessor_load_aligner.sv
// Extracts the addressed byte/half/word lane from a 32-bit bus word and
// sign- or zero-extends it; any case without a sub-word flag returns the word.
module accessor_load_aligner (
    input  logic [31:0] i_rdata,
    input  logic [1:0]  i_addr,
    input  logic        i_is_lb,
    input  logic        i_is_lbu,
    input  logic        i_is_lh,
    input  logic        i_is_lhu,
    output logic [31:0] o_result
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    always_comb begin
        case (i_addr)
            2'd0:    w_byte = i_rdata[7:0];
            2'd1:    w_byte = i_rdata[15:8];
            2'd2:    w_byte = i_rdata[23:16];
            default: w_byte = i_rdata[31:24];
        endcase
        w_half   = i_addr[1] ? i_rdata[31:16] : i_rdata[15:0];
        o_result = i_rdata;
        if (i_is_lb)
            o_result = {{24{w_byte[7]}}, w_byte};
        else if (i_is_lbu)
            o_result = {24'h0, w_byte};
        else if (i_is_lh)
            o_result = {{16{w_half[15]}}, w_half};
        else if (i_is_lhu)
            o_result = {16'h0, w_half};
    end

endmodule

// File: rtl/accessor.sv
// Memory-access pipeline stage: passes ALU results through and runs one
// aligned data-bus transaction per load/store, with misalign and timeout checks.
module accessor
    import accessor_pkg::*;
#(
    parameter int MEM_TIMEOUT = 16
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           executor_valid,
    output logic           accessor_ready,
    input  executor_output in,
    output logic           accessor_valid,
    input  logic           writeback_ready,
    output accessor_output out,
    output logic           mem_valid,
    input  logic           mem_ready,
    output logic [31:0]    mem_addr,
    output logic [31:0]    mem_wdata,
    output logic [3:0]     mem_wstrb,
    input  logic [31:0]    mem_rdata
);

    localparam int CW = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
    localparam logic [CW-1:0] TMO_LAST = CW'((MEM_TIMEOUT > 0) ? MEM_TIMEOUT - 1 : 0);

    accessor_state_e r_state;
    logic [CW-1:0]   r_cnt;
    logic [4:0]      r_rd;
    logic [1:0]      r_addr_lo;
    logic            r_load;
    logic            r_lb;
    logic            r_lbu;
    logic            r_lh;
    logic            r_lhu;

    logic            w_accept;
    logic            w_timeout;
    logic [3:0]      w_wstrb;
    logic [31:0]     w_wdata;
    logic [31:0]     w_load_data;

    assign accessor_ready = (r_state == ST_IDLE) || (r_state == ST_HOLD && writeback_ready);
    assign w_accept       = executor_valid && accessor_ready;
    assign w_timeout      = (MEM_TIMEOUT > 0) && (r_cnt == TMO_LAST);

    always_comb begin
        w_wstrb = 4'b0000;
        w_wdata = 32'h0;
        if (in.is_sb) begin
            w_wstrb = WSTRB_BYTE << in.mem_addr[1:0];
            w_wdata = {4{in.mem_data[7:0]}};
        end else if (in.is_sh) begin
            w_wstrb = WSTRB_HALF << in.mem_addr[1:0];
            w_wdata = {2{in.mem_data[15:0]}};
        end else if (in.is_sw) begin
            w_wstrb = WSTRB_WORD;
            w_wdata = in.mem_data;
        end
    end

    accessor_load_aligner u_load_aligner (
        .i_rdata  (mem_rdata),
        .i_addr   (r_addr_lo),
        .i_is_lb  (r_lb),
        .i_is_lbu (r_lbu),
        .i_is_lh  (r_lh),
        .i_is_lhu (r_lhu),
        .o_result (w_load_data)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state        <= ST_IDLE;
            r_cnt          <= '0;
            r_rd           <= '0;
            r_addr_lo      <= '0;
            r_load         <= 1'b0;
            r_lb           <= 1'b0;
            r_lbu          <= 1'b0;
            r_lh           <= 1'b0;
            r_lhu          <= 1'b0;
            accessor_valid <= 1'b0;
            out            <= '0;
            mem_valid      <= 1'b0;
            mem_addr       <= '0;
            mem_wdata      <= '0;
            mem_wstrb      <= '0;
        end else begin
            case (r_state)
                ST_BUS: begin
                    // A completion in the timeout cycle takes priority over the abort.
                    if (mem_ready) begin
                        r_state        <= ST_HOLD;
                        mem_valid      <= 1'b0;
                        mem_wstrb      <= 4'b0000;
                        accessor_valid <= 1'b1;
                        out            <= r_load ? accessor_output'{rd: r_rd, rd_data: w_load_data,
                                                                    misaligned: 1'b0, bus_error: 1'b0}
                                                 : '0;
                    end else if (w_timeout) begin
                        r_state        <= ST_HOLD;
                        mem_valid      <= 1'b0;
                        mem_wstrb      <= 4'b0000;
                        accessor_valid <= 1'b1;
                        out            <= accessor_output'{rd: 5'd0, rd_data: 32'h0,
                                                           misaligned: 1'b0, bus_error: 1'b1};
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                default: begin
                    if (w_accept) begin
                        if (!is_mem_op(in)) begin
                            r_state        <= ST_HOLD;
                            accessor_valid <= 1'b1;
                            out            <= accessor_output'{rd: in.rd, rd_data: in.rd_data,
                                                               misaligned: 1'b0, bus_error: 1'b0};
                        end else if (is_misaligned(in)) begin
                            r_state        <= ST_HOLD;
                            accessor_valid <= 1'b1;
                            out            <= accessor_output'{rd: 5'd0, rd_data: 32'h0,
                                                               misaligned: 1'b1, bus_error: 1'b0};
                        end else begin
                            r_state        <= ST_BUS;
                            accessor_valid <= 1'b0;
                            mem_valid      <= 1'b1;
                            mem_addr       <= {in.mem_addr[31:2], 2'b00};
                            mem_wdata      <= w_wdata;
                            mem_wstrb      <= w_wstrb;
                            r_cnt          <= '0;
                            r_rd           <= in.rd;
                            r_addr_lo      <= in.mem_addr[1:0];
                            r_load         <= in.is_lb | in.is_lbu | in.is_lh | in.is_lhu | in.is_lw;
                            r_lb           <= in.is_lb;
                            r_lbu          <= in.is_lbu;
                            r_lh           <= in.is_lh;
                            r_lhu          <= in.is_lhu;
                        end
                    end else if (r_state == ST_HOLD && writeback_ready) begin
                        r_state        <= ST_IDLE;
                        accessor_valid <= 1'b0;
                    end
                end
            endcase
        end
    end

`ifdef FORMAL
    always_comb begin
        if (executor_valid)
            assume ($onehot0({in.is_lb, in.is_lbu, in.is_lh, in.is_lhu,
                              in.is_lw, in.is_sb, in.is_sh, in.is_sw}));
    end
`endif

endmodule

// File: tb/tb_accessor.sv
// Directed and randomized checks of the accessor stage against an
// arithmetic reference model of the access rules.
module tb_accessor;
    import accessor_pkg::*;

    localparam int TMO = 4;

    typedef enum int {OP_ALU, OP_LB, OP_LBU, OP_LH, OP_LHU, OP_LW, OP_SB, OP_SH, OP_SW} op_e;

    logic           clk = 1'b0;
    logic           reset = 1'b0;
    logic           executor_valid = 1'b0;
    logic           accessor_ready;
    executor_output in_op = '0;
    logic           accessor_valid;
    logic           writeback_ready = 1'b1;
    accessor_output out_res;
    logic           mem_valid;
    logic           mem_ready = 1'b0;
    logic [31:0]    mem_addr;
    logic [31:0]    mem_wdata;
    logic [3:0]     mem_wstrb;
    logic [31:0]    mem_rdata = 32'h0;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    accessor #(.MEM_TIMEOUT(TMO)) dut (
        .clk             (clk),
        .reset           (reset),
        .executor_valid  (executor_valid),
        .accessor_ready  (accessor_ready),
        .in              (in_op),
        .accessor_valid  (accessor_valid),
        .writeback_ready (writeback_ready),
        .out             (out_res),
        .mem_valid       (mem_valid),
        .mem_ready       (mem_ready),
        .mem_addr        (mem_addr),
        .mem_wdata       (mem_wdata),
        .mem_wstrb       (mem_wstrb),
        .mem_rdata       (mem_rdata)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int op_size(input op_e op);
        case (op)
            OP_LB, OP_LBU, OP_SB: return 1;
            OP_LH, OP_LHU, OP_SH: return 2;
            OP_LW, OP_SW:         return 4;
            default:              return 0;
        endcase
    endfunction

    function automatic bit op_is_load(input op_e op);
        return op == OP_LB || op == OP_LBU || op == OP_LH || op == OP_LHU || op == OP_LW;
    endfunction

    function automatic executor_output make_in(input op_e op, input logic [4:0] rd,
                                               input logic [31:0] rdd, input logic [31:0] addr,
                                               input logic [31:0] data);
        executor_output x;
        x          = '0;
        x.rd       = rd;
        x.rd_data  = rdd;
        x.mem_addr = addr;
        x.mem_data = data;
        x.is_lb    = (op == OP_LB);
        x.is_lbu   = (op == OP_LBU);
        x.is_lh    = (op == OP_LH);
        x.is_lhu   = (op == OP_LHU);
        x.is_lw    = (op == OP_LW);
        x.is_sb    = (op == OP_SB);
        x.is_sh    = (op == OP_SH);
        x.is_sw    = (op == OP_SW);
        return x;
    endfunction

    // Expected writeback payload; delay is the bus cycle on which mem_ready arrives.
    function automatic accessor_output ref_out(input op_e op, input logic [4:0] rd,
                                               input logic [31:0] rdd, input logic [31:0] addr,
                                               input logic [31:0] rdata, input int delay);
        accessor_output  r;
        int              sz;
        int unsigned     a;
        longint unsigned v;
        longint unsigned span;
        r    = '0;
        sz   = op_size(op);
        a    = addr % 4;
        if (sz == 0) begin
            r.rd      = rd;
            r.rd_data = rdd;
            return r;
        end
        if (a % sz != 0) begin
            r.misaligned = 1'b1;
            return r;
        end
        if (delay > TMO) begin
            r.bus_error = 1'b1;
            return r;
        end
        if (op_is_load(op)) begin
            span = 64'd1 << (8 * sz);
            v    = ({32'h0, rdata} >> (8 * a)) % span;
            if ((op == OP_LB || op == OP_LH) && v >= span / 2)
                v = v - span;
            r.rd      = rd;
            r.rd_data = v[31:0];
        end
        return r;
    endfunction

    task automatic run_op(input string tag, input op_e op, input logic [4:0] rd,
                          input logic [31:0] rdd, input logic [31:0] addr, input logic [31:0] data,
                          input logic [31:0] rdata, input int delay, input int hold);
        accessor_output  exp_o;
        int              sz;
        int              exp_bus;
        int              n_bus;
        int              guard;
        longint unsigned strb;
        longint unsigned wd;
        logic [31:0]     exp_addr;
        sz      = op_size(op);
        exp_o   = ref_out(op, rd, rdd, addr, rdata, delay);
        exp_bus = (sz == 0 || (addr % 4) % sz != 0) ? 0 : ((delay > TMO) ? TMO : delay);
        exp_addr = addr - (addr % 4);
        strb = 0;
        wd   = 0;
        if (op == OP_SB || op == OP_SH || op == OP_SW) begin
            strb = ((64'd1 << sz) - 1) << (addr % 4);
            for (int k = 0; k < 4 / sz; k++)
                wd = wd + ((data % (64'd1 << (8 * sz))) << (8 * sz * k));
        end
        writeback_ready = (hold == 0);
        in_op           = make_in(op, rd, rdd, addr, data);
        executor_valid  = 1'b1;
        chk({tag, ".ready_in"}, accessor_ready, 1);
        @(posedge clk);
        @(negedge clk);
        executor_valid = 1'b0;
        in_op          = '0;
        in_op.rd_data  = $urandom;
        in_op.mem_addr = $urandom;
        in_op.mem_data = $urandom;
        in_op.is_sw    = 1'b1;
        n_bus = 0;
        guard = 0;
        while (!accessor_valid && guard < 64) begin
            chk({tag, ".bus_valid"}, mem_valid, 1);
            chk({tag, ".bus_noready"}, accessor_ready, 0);
            chk({tag, ".bus_addr"}, mem_addr, exp_addr);
            chk({tag, ".bus_wstrb"}, mem_wstrb, strb[3:0]);
            chk({tag, ".bus_wdata"}, mem_wdata, wd[31:0]);
            n_bus++;
            mem_ready = (n_bus == delay);
            mem_rdata = (n_bus == delay) ? rdata : $urandom;
            @(posedge clk);
            @(negedge clk);
            mem_ready = 1'b0;
            guard++;
        end
        chk({tag, ".out_valid"}, accessor_valid, 1);
        chk({tag, ".bus_cycles"}, n_bus, exp_bus);
        chk({tag, ".out"}, out_res, exp_o);
        chk({tag, ".mem_idle"}, mem_valid, 0);
        for (int i = 0; i < hold; i++) begin
            chk({tag, ".hold_out"}, out_res, exp_o);
            chk({tag, ".hold_valid"}, accessor_valid, 1);
            chk({tag, ".hold_noready"}, accessor_ready, 0);
            @(posedge clk);
            @(negedge clk);
        end
        writeback_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk({tag, ".drained"}, accessor_valid, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        op_e         op;
        logic [31:0] addr;
        int          sz;

        #1;
        chk("rst.valid", accessor_valid, 0);
        chk("rst.ready", accessor_ready, 1);
        chk("rst.mem_valid", mem_valid, 0);
        chk("rst.mem_addr", mem_addr, 0);
        chk("rst.mem_wstrb", mem_wstrb, 0);
        chk("rst.mem_wdata", mem_wdata, 0);
        chk("rst.out", out_res, 0);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);

        // ALU passthrough, back-to-back
        writeback_ready = 1'b1;
        in_op           = make_in(OP_ALU, 5'd5, 32'hDEADBEEF, 32'h0, 32'h0);
        executor_valid  = 1'b1;
        chk("alu.ready0", accessor_ready, 1);
        @(posedge clk);
        @(negedge clk);
        chk("alu.valid1", accessor_valid, 1);
        chk("alu.out1", out_res, accessor_output'{rd: 5'd5, rd_data: 32'hDEADBEEF, misaligned: 1'b0, bus_error: 1'b0});
        chk("alu.ready1", accessor_ready, 1);
        in_op = make_in(OP_ALU, 5'd7, 32'h12345678, 32'h0, 32'h0);
        @(posedge clk);
        @(negedge clk);
        chk("alu.valid2", accessor_valid, 1);
        chk("alu.out2", out_res, accessor_output'{rd: 5'd7, rd_data: 32'h12345678, misaligned: 1'b0, bus_error: 1'b0});
        executor_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("alu.drained", accessor_valid, 0);

        run_op("lb",      OP_LB,  5'd3, 32'h0, 32'h0000_1003, 32'h0,        32'h80FF_1234, 3, 0);
        chk("lb.value_ref", ref_out(OP_LB, 5'd3, 32'h0, 32'h1003, 32'h80FF1234, 3),
            accessor_output'{rd: 5'd3, rd_data: 32'hFFFFFF80, misaligned: 1'b0, bus_error: 1'b0});
        run_op("lbu",     OP_LBU, 5'd4, 32'h0, 32'h0000_1003, 32'h0,        32'h80FF_1234, 3, 0);
        run_op("sh",      OP_SH,  5'd9, 32'h0, 32'h0000_2002, 32'h0000ABCD, 32'h0,         1, 0);
        run_op("lw_mis",  OP_LW,  5'd2, 32'h0, 32'h0000_3001, 32'h0,        32'h0,         1, 0);
        run_op("lw_tmo",  OP_LW,  5'd6, 32'h0, 32'h0000_4000, 32'h0,        32'h0,       100, 0);
        run_op("lw_edge", OP_LW,  5'd6, 32'h0, 32'h0000_4000, 32'h0,        32'hCAFEF00D,  4, 0);
        run_op("lh_hold", OP_LH,  5'd8, 32'h0, 32'h0000_5002, 32'h0,        32'h8001_7FFF, 2, 5);

        for (int n = 0; n < 40; n++) begin
            op   = op_e'($urandom_range(0, 8));
            sz   = op_size(op);
            addr = $urandom;
            if ($urandom_range(0, 1) == 1 && sz > 1)
                addr = addr - (addr % sz);
            run_op($sformatf("rnd%0d", n), op, 5'($urandom), $urandom, addr, $urandom,
                   $urandom, int'($urandom_range(1, 6)), int'($urandom_range(0, 2)));
        end

        // Reset in the middle of a bus transaction
        in_op          = make_in(OP_SW, 5'd1, 32'h0, 32'h0000_6000, 32'h11223344);
        executor_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        executor_valid = 1'b0;
        chk("rstbus.pre_valid", mem_valid, 1);
        #2;
        reset = 1'b0;
        #1;
        chk("rstbus.mem_valid", mem_valid, 0);
        chk("rstbus.mem_addr", mem_addr, 0);
        chk("rstbus.mem_wstrb", mem_wstrb, 0);
        chk("rstbus.mem_wdata", mem_wdata, 0);
        chk("rstbus.valid", accessor_valid, 0);
        chk("rstbus.out", out_res, 0);
        @(negedge clk);
        reset = 1'b1;
        #1;
        chk("rstbus.idle_ready", accessor_ready, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
